// File: rtl/z88_memif.sv
// ============================================================================
// z88_memif : Blink chip-select slot interface onto one shared async SRAM bus.
// Optional Z88_MEMIF_STATS_EN adds saturating rd_count/wr_count outputs.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module z88_memif #(
  parameter int                NCS       = 5,
  parameter int                AW        = 19,
  parameter int                DW        = 8,
  parameter int                RD_WAIT   = 2,
  parameter int                WR_WAIT   = 2,
  parameter logic [NCS-1:0]    WP_MASK   = 5'b00001,
  parameter logic [DW-1:0]     IDLE_DATA = 8'hFF,
  localparam int               SW        = $clog2(NCS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCS-1:0]    cs_n,
  input  logic [AW-1:0]     ma,
  input  logic              roe_n,
  input  logic              wrb_n,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata,
  output logic              rvalid,
  output logic              wait_n,
  output logic [SW+AW-1:0]  ext_a,
  output logic [DW-1:0]     ext_do,
  input  logic [DW-1:0]     ext_di,
  output logic              ext_ce_n,
  output logic              ext_oe_n,
  output logic              ext_we_n,
  output logic              wp_err
`ifdef Z88_MEMIF_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [3:0] RD_N = 4'(RD_WAIT);
  localparam logic [3:0] WR_N = 4'(WR_WAIT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_HOLD = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              dir_rd_q, dir_rd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SW+AW-1:0]  ext_a_q, ext_a_d;
  logic [DW-1:0]     ext_do_q, ext_do_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wp_err_q, wp_err_d;
`ifdef Z88_MEMIF_STATS_EN
  logic [15:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
`endif

  logic              req, is_rd, prot, last, hold_ok, wait_c;
  logic [SW-1:0]     sel;

  // Lowest-numbered active select wins.
  always_comb begin
    sel = '0;
    for (int i = NCS - 1; i >= 0; i--) begin
      if (!cs_n[i]) sel = SW'(i);
    end
  end

  assign req     = ~&cs_n & (~roe_n | ~wrb_n);
  assign is_rd   = ~roe_n;
  assign prot    = ~is_rd & WP_MASK[sel];
  assign last    = (cnt_q == (dir_rd_q ? RD_N : WR_N));
  assign hold_ok = ~cs_n[sel_q] & (dir_rd_q ? ~roe_n : ~wrb_n);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dir_rd_d = dir_rd_q;
    cnt_d    = cnt_q;
    ext_a_d  = ext_a_q;
    ext_do_d = ext_do_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    wp_err_d = 1'b0;
    wait_c   = 1'b1;
`ifdef Z88_MEMIF_STATS_EN
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        wait_c = ~req;
        if (req) begin
          state_d  = S_ACCESS;
          sel_d    = sel;
          dir_rd_d = is_rd;
          cnt_d    = 4'd0;
          ext_a_d  = {sel, ma};
          // Protected writes run the full timing with the SRAM left deselected.
          ce_n_d   = prot;
          oe_n_d   = ~is_rd;
          we_n_d   = is_rd | prot;
          wp_err_d = prot;
          if (!is_rd && !prot) ext_do_d = wdata;
        end
      end
      S_ACCESS: begin
        wait_c = 1'b0;
        cnt_d  = cnt_q + 4'd1;
        if (last) begin
          state_d = S_HOLD;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (dir_rd_q) begin
            rdata_d  = ext_di;
            rvalid_d = 1'b1;
          end
`ifdef Z88_MEMIF_STATS_EN
          if (dir_rd_q && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
          if (!dir_rd_q && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
`endif
        end
      end
      S_HOLD: begin
        if (!hold_ok) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
          rdata_d  = IDLE_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      dir_rd_q <= 1'b0;
      cnt_q    <= 4'd0;
      ext_a_q  <= '0;
      ext_do_q <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      rdata_q  <= IDLE_DATA;
      rvalid_q <= 1'b0;
      wp_err_q <= 1'b0;
`ifdef Z88_MEMIF_STATS_EN
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      dir_rd_q <= dir_rd_d;
      cnt_q    <= cnt_d;
      ext_a_q  <= ext_a_d;
      ext_do_q <= ext_do_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wp_err_q <= wp_err_d;
`ifdef Z88_MEMIF_STATS_EN
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
`endif
    end
  end

  // Reset overrides the combinational stall so the CPU is never held in reset.
  assign wait_n   = ~reset_n | wait_c;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign ext_a    = ext_a_q;
  assign ext_do   = ext_do_q;
  assign ext_ce_n = ce_n_q;
  assign ext_oe_n = oe_n_q;
  assign ext_we_n = we_n_q;
  assign wp_err   = wp_err_q;
`ifdef Z88_MEMIF_STATS_EN
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_z88_memif.sv
// ============================================================================
// tb_z88_memif : directed self-checking bench for z88_memif (RD_WAIT=2, WR_WAIT=0).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_z88_memif;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  cs_n;
  logic [18:0] ma;
  logic        roe_n, wrb_n;
  logic [7:0]  wdata, rdata, ext_do, ext_di;
  logic        rvalid, wait_n, ext_ce_n, ext_oe_n, ext_we_n, wp_err;
  logic [21:0] ext_a;
`ifdef Z88_MEMIF_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  always #5 clk = ~clk;

  z88_memif #(.RD_WAIT(2), .WR_WAIT(0)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .ma(ma), .roe_n(roe_n),
    .wrb_n(wrb_n), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .wait_n(wait_n), .ext_a(ext_a), .ext_do(ext_do), .ext_di(ext_di),
    .ext_ce_n(ext_ce_n), .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n),
    .wp_err(wp_err)
`ifdef Z88_MEMIF_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Per-access observations gathered over an 8-cycle window starting at T0.
  int          wl, ol, wel, cel, wpc, first_rv;
  logic [21:0] a_seen;
  logic [7:0]  do_seen, rd_seen;

  task automatic access(input logic [4:0] cs, input logic [18:0] addr, input logic rd,
                        input logic wr, input logic [7:0] wd, input logic [7:0] di,
                        input int di_cyc);
    wl = 0; ol = 0; wel = 0; cel = 0; wpc = 0; first_rv = -1;
    a_seen = '0; do_seen = '0; rd_seen = '0;
    cs_n = cs; ma = addr; roe_n = ~rd; wrb_n = ~wr; wdata = wd;
    for (int i = 0; i < 8; i++) begin
      ext_di = (i == di_cyc) ? di : 8'h00;
      if (i == 1) begin
        wdata = ~wd;
        ma    = ~addr;
      end
      #1;
      if (!wait_n) wl++;
      if (!ext_oe_n) ol++;
      if (!ext_ce_n) begin cel++; a_seen = ext_a; end
      if (!ext_we_n) begin wel++; do_seen = ext_do; end
      if (wp_err) wpc++;
      if (rvalid && first_rv < 0) begin first_rv = i; rd_seen = rdata; end
      tick;
    end
  endtask

  task automatic release_bus;
    cs_n = 5'h1F; roe_n = 1'b1; wrb_n = 1'b1;
    tick;
  endtask

  initial begin
    reset_n = 1'b0; cs_n = 5'b11101; ma = 19'h12345; roe_n = 1'b0; wrb_n = 1'b0;
    wdata = 8'h11; ext_di = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rst_ce", 32'(ext_ce_n), 32'h1);
      check("rst_oe", 32'(ext_oe_n), 32'h1);
      check("rst_we", 32'(ext_we_n), 32'h1);
      check("rst_wait", 32'(wait_n), 32'h1);
      check("rst_rdata", 32'(rdata), 32'hFF);
      check("rst_rvalid", 32'(rvalid), 32'h0);
    end
    check("rst_ext_a", 32'(ext_a), 32'h0);
    check("rst_ext_do", 32'(ext_do), 32'h0);
    check("rst_wp", 32'(wp_err), 32'h0);
    cs_n = 5'h1F; roe_n = 1'b1; wrb_n = 1'b1;
    reset_n = 1'b1;
    tick;

    // Read slot 1, N=2: data presented only on the last ACCESS cycle (T0+3).
    access(5'b11101, 19'h12345, 1'b1, 1'b0, 8'h00, 8'hA5, 3);
    check("rd_wait_cycles", 32'(wl), 32'd4);
    check("rd_oe_cycles", 32'(ol), 32'd3);
    check("rd_ce_cycles", 32'(cel), 32'd3);
    check("rd_we_cycles", 32'(wel), 32'd0);
    check("rd_ext_a", 32'(a_seen), {10'd0, 3'd1, 19'h12345});
    check("rd_first_valid", 32'(first_rv), 32'd4);
    check("rd_data", 32'(rd_seen), 32'hA5);
    check("rd_hold_valid", 32'(rvalid), 32'h1);
    release_bus;
    check("rd_rel_valid", 32'(rvalid), 32'h0);
    check("rd_rel_data", 32'(rdata), 32'hFF);
    tick;

    // Write slot 3, N=0.
    access(5'b10111, 19'h0ABCD, 1'b0, 1'b1, 8'h3C, 8'h00, -1);
    check("wr_we_cycles", 32'(wel), 32'd1);
    check("wr_ce_cycles", 32'(cel), 32'd1);
    check("wr_ext_do", 32'(do_seen), 32'h3C);
    check("wr_ext_a", 32'(a_seen), {10'd0, 3'd3, 19'h0ABCD});
    check("wr_wp", 32'(wpc), 32'd0);
    check("wr_wait_cycles", 32'(wl), 32'd2);
    check("wr_oe_cycles", 32'(ol), 32'd0);
    check("wr_no_valid", 32'(first_rv), 32'hFFFFFFFF);
    release_bus;
    tick;

    // Protected write to slot 0.
    access(5'b11110, 19'h00042, 1'b0, 1'b1, 8'h99, 8'h00, -1);
    check("wp_we_cycles", 32'(wel), 32'd0);
    check("wp_ce_cycles", 32'(cel), 32'd0);
    check("wp_pulse", 32'(wpc), 32'd1);
    check("wp_wait_cycles", 32'(wl), 32'd2);
    release_bus;
    tick;

    // Slots 2 and 3 selected, both strobes low: read from slot 2.
    access(5'b10011, 19'h7FFFF, 1'b1, 1'b1, 8'h00, 8'h5A, 3);
    check("sim_ext_a", 32'(a_seen), {10'd0, 3'd2, 19'h7FFFF});
    check("sim_we_cycles", 32'(wel), 32'd0);
    check("sim_oe_cycles", 32'(ol), 32'd3);
    check("sim_data", 32'(rd_seen), 32'h5A);
    release_bus;
    tick;
`ifdef Z88_MEMIF_STATS_EN
    check("st_rd_pre", 32'(rd_count), 32'd2);
    check("st_wr_pre", 32'(wr_count), 32'd2);
`endif

    // Reset during the single ACCESS cycle of a write.
    cs_n = 5'b11101; ma = 19'h00010; wrb_n = 1'b0; wdata = 8'h77;
    #1;
    check("mid_t0_wait", 32'(wait_n), 32'h0);
    tick;
    check("mid_acc_we", 32'(ext_we_n), 32'h0);
    reset_n = 1'b0;
    tick;
    check("mid_rst_we", 32'(ext_we_n), 32'h1);
    check("mid_rst_ce", 32'(ext_ce_n), 32'h1);
    check("mid_rst_valid", 32'(rvalid), 32'h0);
`ifdef Z88_MEMIF_STATS_EN
    check("mid_wr_count", 32'(wr_count), 32'd0);
`endif
    reset_n = 1'b1;
    release_bus;
    tick;
    for (int k = 0; k < 3; k++) begin
      access(5'b11011, 19'(k), 1'b1, 1'b0, 8'h00, 8'(8'h30 + k), 3);
      check("post_rd_data", 32'(rd_seen), 32'(8'h30 + k));
      release_bus;
      tick;
    end
    check("post_rel_valid", 32'(rvalid), 32'h0);
`ifdef Z88_MEMIF_STATS_EN
    check("post_rd_count", 32'(rd_count), 32'd3);
    check("post_wr_count", 32'(wr_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/z88_memif.md
Name: z88_memif

Overview:
Parametrised slot memory interface between the Blink chip-select/strobe outputs and one shared external asynchronous SRAM bus.
- Generalises the fixed slot-0 RAM/ROM glue to NCS chip selects (internal ROM, internal RAM, card slots 1-3).
- Programmable read/write wait states; wait_n stretches CPU cycles.
- Per-slot write protection.
- Registered read-data path with a valid flag, feeding the Blink CPU-data mux.

Parameters:
NCS, 5, number of chip selects; bit0=ipce_n, bit1=irce_n, bits2..4=se1_n..se3_n
AW, 19, per-slot address width
DW, 8, data width
SW, $clog2(NCS), slot-index width (derived, not overridden)
RD_WAIT, 2, extra ACCESS cycles for reads (0..15)
WR_WAIT, 2, extra ACCESS cycles for writes (0..15)
WP_MASK, 5'b00001, 1 = slot write-protected
IDLE_DATA, 8'hFF, rdata value when not valid

Ports:
clk  in  1  system clock (all logic on rising edge)
reset_n  in  1  synchronous active-low reset
cs_n  in  NCS  active-low chip selects from Blink
ma  in  AW  memory address from Blink
roe_n  in  1  read strobe, active low
wrb_n  in  1  write strobe, active low
wdata  in  DW  CPU write data
rdata  out  DW  latched read data to Blink cdi mux
rvalid  out  1  rdata holds valid read data
wait_n  out  1  to CPU wait_n, active low
ext_a  out  SW+AW  {slot index, address}
ext_do  out  DW  write data to SRAM
ext_di  in  DW  read data from SRAM
ext_ce_n  out  1  SRAM chip enable
ext_oe_n  out  1  SRAM output enable
ext_we_n  out  1  SRAM write enable
wp_err  out  1  one-cycle pulse on a write to a protected slot

Behaviour:
- One clock domain. Reset is synchronous, active-low, dominates all other logic.
- Reset values: state IDLE; ext_ce_n, ext_oe_n, ext_we_n = 1; wait_n = 1; rdata = IDLE_DATA; rvalid = 0; wp_err = 0; ext_a = 0; ext_do = 0; counter = 0.
- req = (any cs_n bit low) AND (roe_n low OR wrb_n low).
- Slot selection: sel = lowest index with cs_n low; other simultaneous selects are ignored.
- Direction: if roe_n and wrb_n are both low, the access is a read.
- States: IDLE, ACCESS, HOLD.
- IDLE:
  - wait_n = !req, combinational, so the CPU is stalled in the detect cycle.
  - On req: register sel, ma, wdata and dir; counter = 0; go to ACCESS.
- ACCESS:
  - wait_n = 0; ext_a = {sel, ma_latched}; ext_ce_n = 0.
  - Read: ext_oe_n = 0.
  - Write to an unprotected slot: ext_we_n = 0; ext_do = wdata_latched.
  - Write to a protected slot (WP_MASK[sel] = 1): ext_ce_n and ext_we_n stay 1; wp_err pulses in the first ACCESS cycle. Timing is identical to a normal write.
  - Counter increments each cycle. Leave ACCESS after N+1 cycles (N = RD_WAIT or WR_WAIT).
  - On the last read cycle, register ext_di into rdata and set rvalid = 1.
  - Go to HOLD.
- HOLD:
  - All ext strobes = 1; wait_n = 1; rdata/rvalid held.
  - Stay while the latched slot's cs_n is low and the strobe for the latched direction is low.
  - Otherwise go to IDLE with rvalid = 0 and rdata = IDLE_DATA.
- Read latency: detect cycle T0; rdata valid from T0+N+2. wait_n is low for exactly N+2 cycles (T0..T0+N+1).
- N = 0: ACCESS lasts one cycle.
- Strobes or cs_n released mid-ACCESS: the access completes unchanged; HOLD exits on the next cycle.
- A new request can only start from IDLE, so back-to-back accesses have at least one IDLE cycle.
- Reset mid-access: the external cycle is aborted; strobes are 1 after that edge; no rvalid.
- ext_a, ext_do and the strobes are registered outputs, so there are no glitches.

Optional Feature:
Z88_MEMIF_STATS_EN
- Defined: adds outputs rd_count[15:0] and wr_count[15:0].
  - Each counts completed accesses, incremented on ACCESS exit.
  - Saturate at 16'hFFFF.
  - Protected writes are counted in wr_count.
  - Cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with requests active -> all strobes 1, wait_n=1, rdata=8'hFF, rvalid=0.
- Read, RD_WAIT=2: cs_n=5'b11101, ma=19'h12345, roe_n=0, ext_di=8'hA5 -> ext_a={3'd1,19'h12345}; wait_n low for 4 cycles; ext_oe_n low for 3 cycles; rdata=8'hA5 and rvalid=1 from T0+4 until roe_n rises.
- Write to slot 3, WR_WAIT=0: wdata=8'h3C -> ext_we_n low for exactly 1 cycle with ext_do=8'h3C and ext_a[21:19]=3; wp_err=0.
- Protected write to slot 0: wrb_n=0, cs_n=5'b11110 -> ext_we_n and ext_ce_n never low; wp_err high for 1 cycle; wait_n low for WR_WAIT+2 cycles.
- Simultaneous selects: cs_n=5'b10011 (slots 2 and 3 low) -> ext_a slot field=2. Both strobes low -> read performed, ext_we_n stays 1.
- Reset mid-ACCESS during a write, with Z88_MEMIF_STATS_EN defined -> ext_we_n=1 after that edge; wr_count=0. Afterwards 3 reads give rd_count=3.
